// File: rtl/branch_predictor.sv
// IF-stage branch predictor: a table of 2-bit saturating counters, indexed by PC,
// optionally XORed with a non-speculative global history (gshare), and trained from MEM.
module branch_predictor #(
  parameter int INDEX_BITS   = 6,
  parameter int HISTORY_BITS = 0,
  parameter int STAT_BITS    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Fetch_PC,
  input  logic                  Fetch_Branch,
  output logic                  Predicted,
  output logic [INDEX_BITS-1:0] Predicted_Index,
  input  logic                  Update_Enable,
  input  logic [INDEX_BITS-1:0] Update_Index,
  input  logic                  Decision,
  input  logic                  Mistake,
  output logic [STAT_BITS-1:0]  Branch_Count,
  output logic [STAT_BITS-1:0]  Mispredict_Count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            pht [ENTRIES];
  logic [INDEX_BITS-1:0] hist_ext;
  logic [1:0]            cur_cnt;
  logic [1:0]            next_cnt;
  logic                  mispredict;
  logic [STAT_BITS-1:0]  branch_cnt;
  logic [STAT_BITS-1:0]  miss_cnt;
  logic                  unused_pc;

  assign unused_pc = ^{Fetch_PC[31:INDEX_BITS+2], Fetch_PC[1:0]};

  // History only advances when a branch resolves, so fetch never sees wrong-path outcomes.
  generate
    if (HISTORY_BITS == 0) begin : g_bimodal
      assign hist_ext = '0;
    end else if (HISTORY_BITS == 1) begin : g_gshare1
      logic ghr;
      always_ff @(posedge clk) begin
        if (reset)
          ghr <= 1'b0;
        else if (Update_Enable)
          ghr <= Decision;
      end
      assign hist_ext = INDEX_BITS'(ghr);
    end else begin : g_gshare
      logic [HISTORY_BITS-1:0] ghr;
      always_ff @(posedge clk) begin
        if (reset)
          ghr <= '0;
        else if (Update_Enable)
          ghr <= {ghr[HISTORY_BITS-2:0], Decision};
      end
      assign hist_ext = INDEX_BITS'(ghr);
    end
  endgenerate

  assign Predicted_Index = Fetch_PC[INDEX_BITS+1:2] ^ hist_ext;
  assign Predicted       = Fetch_Branch & pht[Predicted_Index][1];

  always_comb begin
    cur_cnt  = pht[Update_Index];
    next_cnt = cur_cnt;
    if (Decision && cur_cnt != 2'b11)
      next_cnt = cur_cnt + 2'd1;
    else if (!Decision && cur_cnt != 2'b00)
      next_cnt = cur_cnt - 2'd1;
    // Not-taken mispredicts arrive as Mistake; taken mispredicts are detected here.
    mispredict = Mistake | (Decision & ~cur_cnt[1]);
  end

  // Flop-based table so one reset cycle restores every entry to weakly not-taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++)
        pht[i] <= 2'b01;
    end else if (Update_Enable) begin
      pht[Update_Index] <= next_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else if (Update_Enable) begin
      if (branch_cnt != '1)
        branch_cnt <= branch_cnt + STAT_BITS'(1);
      if (mispredict && miss_cnt != '1)
        miss_cnt <= miss_cnt + STAT_BITS'(1);
    end
  end

  assign Branch_Count     = branch_cnt;
  assign Mispredict_Count = miss_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a bimodal instance with default sizes plus a
// gshare instance (4-bit history, 4-bit statistics) driven from the same inputs.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Fetch_PC;
  logic        Fetch_Branch;
  logic        Update_Enable;
  logic [5:0]  Update_Index;
  logic        Decision;
  logic        Mistake;

  logic        pred;
  logic [5:0]  pidx;
  logic [15:0] brCnt;
  logic [15:0] missCnt;
  logic        predG;
  logic [5:0]  pidxG;
  logic [3:0]  brCntG;
  logic [3:0]  missCntG;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .reset(reset), .Fetch_PC(Fetch_PC), .Fetch_Branch(Fetch_Branch),
    .Predicted(pred), .Predicted_Index(pidx), .Update_Enable(Update_Enable),
    .Update_Index(Update_Index), .Decision(Decision), .Mistake(Mistake),
    .Branch_Count(brCnt), .Mispredict_Count(missCnt)
  );

  branch_predictor #(.INDEX_BITS(6), .HISTORY_BITS(4), .STAT_BITS(4)) dutg (
    .clk(clk), .reset(reset), .Fetch_PC(Fetch_PC), .Fetch_Branch(Fetch_Branch),
    .Predicted(predG), .Predicted_Index(pidxG), .Update_Enable(Update_Enable),
    .Update_Index(Update_Index), .Decision(Decision), .Mistake(Mistake),
    .Branch_Count(brCntG), .Mispredict_Count(missCntG)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [5:0] idx,
                               input logic dec, input logic mis);
    Update_Enable = en;
    Update_Index  = idx;
    Decision      = dec;
    Mistake       = mis;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    stepClock();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    Fetch_PC     = 32'h0;
    Fetch_Branch = 1'b0;
    applyStimulus(1'b0, 6'h0, 1'b0, 1'b0);
    applyReset();

    // Reset state and initial prediction
    Fetch_PC = 32'h100; Fetch_Branch = 1'b1; #1;
    checkOutput("rst_pred", pred, 0);
    checkOutput("rst_idx", pidx, 6'h00);
    checkOutput("rst_idx_g", pidxG, 6'h00);
    checkOutput("rst_brcnt", brCnt, 0);
    checkOutput("rst_miss", missCnt, 0);

    // Counter training on entry 5 (PC 0x14)
    Fetch_PC = 32'h14; #1;
    checkOutput("idx_pc14", pidx, 6'h05);
    applyStimulus(1'b1, 6'h05, 1'b1, 1'b0);
    stepClock();
    checkOutput("train_t1", pred, 1);
    stepClock();
    checkOutput("train_t2", pred, 1);
    Fetch_Branch = 1'b0; #1;
    checkOutput("nobranch_pred", pred, 0);
    Fetch_Branch = 1'b1;
    applyStimulus(1'b1, 6'h05, 1'b0, 1'b0);
    stepClock();
    checkOutput("train_n1", pred, 1);
    stepClock();
    checkOutput("train_n2", pred, 0);
    stepClock();
    checkOutput("train_n3", pred, 0);
    stepClock();
    checkOutput("train_n4_sat", pred, 0);
    applyStimulus(1'b1, 6'h05, 1'b1, 1'b0);
    stepClock();
    checkOutput("from00_t1", pred, 0);
    stepClock();
    checkOutput("from00_t2", pred, 1);
    applyStimulus(1'b0, 6'h05, 1'b0, 1'b1);
    stepClock();
    checkOutput("hold_pred", pred, 1);
    checkOutput("train_brcnt", brCnt, 8);
    checkOutput("train_miss", missCnt, 3);

    // Same-cycle lookup and update: read-before-write
    applyReset();
    applyStimulus(1'b1, 6'h05, 1'b1, 1'b0); #1;
    checkOutput("collide_same", pred, 0);
    stepClock();
    applyStimulus(1'b0, 6'h05, 1'b0, 1'b0); #1;
    checkOutput("collide_next", pred, 1);

    // Gshare history 1,0,1,1 -> 4'b1011
    applyReset();
    Fetch_PC = 32'h14; #1;
    checkOutput("g_idx_h0", pidxG, 6'h05);
    applyStimulus(1'b1, 6'h20, 1'b1, 1'b0); stepClock();
    applyStimulus(1'b1, 6'h20, 1'b0, 1'b0); stepClock();
    applyStimulus(1'b1, 6'h20, 1'b1, 1'b0); stepClock();
    applyStimulus(1'b1, 6'h20, 1'b1, 1'b0); stepClock();
    applyStimulus(1'b0, 6'h20, 1'b0, 1'b0);
    Fetch_PC = 32'h0; #1;
    checkOutput("g_idx_1011", pidxG, 6'h0B);
    checkOutput("bimodal_idx_pc0", pidx, 6'h00);
    Fetch_PC = 32'h14; #1;
    checkOutput("g_idx_xor", pidxG, 6'h0E);
    stepClock();
    checkOutput("g_idx_hold", pidxG, 6'h0E);

    // Statistics: 3 Mistake updates, then taken updates on 00, 01, 10 entries
    applyReset();
    applyStimulus(1'b1, 6'h10, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) stepClock();
    applyStimulus(1'b1, 6'h10, 1'b1, 1'b0); stepClock();
    applyStimulus(1'b0, 6'h10, 1'b0, 1'b0); #1;
    checkOutput("stat_miss4", missCnt, 4);
    checkOutput("stat_br4", brCnt, 4);
    applyStimulus(1'b1, 6'h10, 1'b1, 1'b0); stepClock();
    stepClock();
    applyStimulus(1'b1, 6'h10, 1'b0, 1'b0); stepClock();
    applyStimulus(1'b0, 6'h10, 1'b0, 1'b1); stepClock();
    checkOutput("stat_br7", brCnt, 7);
    checkOutput("stat_miss5", missCnt, 5);
    checkOutput("stat_br7_g", brCntG, 7);
    applyStimulus(1'b1, 6'h10, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) stepClock();
    checkOutput("sat_br14", brCntG, 14);
    stepClock();
    checkOutput("sat_br15", brCntG, 15);
    checkOutput("sat_miss13", missCntG, 13);
    stepClock();
    stepClock();
    checkOutput("sat_br_hold", brCntG, 15);
    checkOutput("sat_miss15", missCntG, 15);
    checkOutput("wide_br17", brCnt, 17);
    checkOutput("wide_miss15", missCnt, 15);
    stepClock();
    checkOutput("sat_miss_hold", missCntG, 15);

    // Reset mid-training discards the simultaneous update
    applyReset();
    applyStimulus(1'b1, 6'h05, 1'b1, 1'b0);
    stepClock();
    stepClock();
    checkOutput("pre_rst_pred", pred, 1);
    reset = 1'b1;
    applyStimulus(1'b1, 6'h05, 1'b1, 1'b1);
    stepClock();
    reset = 1'b0;
    applyStimulus(1'b0, 6'h05, 1'b0, 1'b0);
    Fetch_PC = 32'h14; #1;
    checkOutput("midrst_pred", pred, 0);
    checkOutput("midrst_pred_g", predG, 0);
    checkOutput("midrst_brcnt", brCnt, 0);
    checkOutput("midrst_miss", missCnt, 0);
    checkOutput("midrst_brcnt_g", brCntG, 0);
    Fetch_PC = 32'h0; #1;
    checkOutput("midrst_ghr", pidxG, 6'h00);
    Fetch_PC = 32'h14;
    applyStimulus(1'b1, 6'h05, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b0, 6'h05, 1'b0, 1'b0); #1;
    checkOutput("midrst_entry01", pred, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage branch predictor. It is the producing end of the Predicted / Decision / Mistake loop that is resolved in MEM.
- It holds a table of 2-bit saturating counters, indexed by PC optionally XORed with a global history register (gshare).
- It issues a taken/not-taken prediction, plus the table index used, for each fetched branch.
- The pipeline carries that index down to MEM. MEM returns the resolved outcome, which trains the table.
- Saturating counters record resolved branches and mispredictions for debug.

Parameters:
- INDEX_BITS, 6: log2 of the number of table entries (64 by default).
- HISTORY_BITS, 0: global history length. 0 gives pure bimodal. Legal range is 0 to INDEX_BITS.
- STAT_BITS, 16: width of each statistics counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Fetch_PC  input  32  PC of the instruction currently in IF.
- Fetch_Branch  input  1  the IF instruction is a conditional branch.
- Predicted  output  1  predict taken. Combinational; forced to 0 when Fetch_Branch=0.
- Predicted_Index  output  INDEX_BITS  table index used for Fetch_PC. The pipeline carries it to MEM.
- Update_Enable  input  1  a conditional branch resolves in MEM this cycle.
- Update_Index  input  INDEX_BITS  index carried with the resolving branch.
- Decision  input  1  resolved outcome: 1 = taken.
- Mistake  input  1  the branch was predicted taken but was not taken.
- Branch_Count  output  STAT_BITS  resolved branches, saturating.
- Mispredict_Count  output  STAT_BITS  mispredictions, saturating.

Behaviour:
- Reset, synchronous and active-high, takes effect at the next rising edge:
  - All table entries are set to 2'b01 (weakly not-taken).
  - The GHR is cleared to 0.
  - Both statistics counters are cleared to 0.
  - Reset has priority over a simultaneous update: an update asserted in a reset cycle is discarded.
- Index computation (combinational):
  - Predicted_Index = Fetch_PC[INDEX_BITS+1:2] XOR {zeros, GHR[HISTORY_BITS-1:0]}.
  - The history is zero-extended into the low bits.
  - With HISTORY_BITS=0 the index is PC bits only.
  - Predicted_Index is driven regardless of Fetch_Branch.
- Prediction: Predicted = Fetch_Branch & table[Predicted_Index][1]. Lookup latency is zero cycles.
- Counter update, applied on the clock edge when Update_Enable=1:
  - If Decision=1, the entry at Update_Index increments, saturating at 2'b11.
  - If Decision=0, it decrements, saturating at 2'b00.
  - Counter state sequence: 00 -> 01 -> 10 -> 11 when taken; the reverse when not taken. There is no hysteresis beyond the 2-bit counter.
- GHR update, when Update_Enable=1 and HISTORY_BITS>0:
  - GHR <= {GHR[HISTORY_BITS-2:0], Decision}, i.e. shift left with the new outcome in the LSB.
  - The GHR is non-speculative: it changes only on resolution, never at fetch.
- Same-cycle lookup and update of the same index: Predicted reflects the pre-update value (read-before-write, no bypass). The new value is visible from the next cycle.
- Update_Enable=0: the table, GHR and counters hold. Decision and Mistake are ignored.
- Statistics, when Update_Enable=1:
  - Branch_Count increments by 1.
  - If Mistake=1, or (Decision=1 and the pre-update table[Update_Index][1]=0), Mispredict_Count increments by 1. This covers both taken-mispredict and not-taken-mispredict.
  - Both counters saturate at all ones and never wrap.
- Mistake without Update_Enable: ignored.
- Table storage is flops, not RAM, so that reset can clear every entry in one cycle.

Test Plan:
1. Reset and initial prediction:
   - Stimulus: assert reset for 1 cycle, then Fetch_PC=0x100, Fetch_Branch=1.
   - Required: Predicted=0, Predicted_Index=0x00 (HISTORY_BITS=0), Branch_Count=0, Mispredict_Count=0.
   - Also: with Fetch_Branch=0, Predicted=0 for any PC.
2. Counter training:
   - Stimulus: Update_Index=0x05, Decision=1 for 2 cycles, Fetch_PC=0x14.
   - Required: Predicted=1 after the first update (01->10), and entry reaches 11 after the second.
   - Then 3 updates with Decision=0: entry goes 11->10->01->00 and Predicted goes 0 after the second. A 4th not-taken update leaves the entry at 00 (saturation).
3. Same-cycle collision:
   - Stimulus: entry 0x05=01; update index 0x05 with Decision=1 while Fetch_PC=0x14.
   - Required: Predicted=0 in that cycle and 1 in the next cycle.
4. Gshare indexing (HISTORY_BITS=4):
   - Stimulus: after reset, updates with Decision=1,0,1,1 (any index), then Fetch_PC=0x00.
   - Required: GHR=4'b1011 and Predicted_Index=0x0B.
5. Statistics:
   - Stimulus: 3 updates with Mistake=1, plus 1 taken update whose entry holds 00, then force Branch_Count to max-1 and send 2 more updates.
   - Required: Mispredict_Count=4 before forcing, and Branch_Count saturates at 0xFFFF.
6. Reset mid-training:
   - Stimulus: update entry 0x05 to 11, then assert reset in the same cycle as Update_Enable=1 on entry 0x05.
   - Required: entry returns to 01, Predicted=0 for PC 0x14, GHR=0, counters=0.
